al_key_entry: RTL
=================

# al_key_entry

Keypad entry stage for the alarm clock: collects four BCD digits from the keypad decoder, validates them as a 24-hour HH:MM value and issues a one-cycle load strobe with the entered value. Sits directly upstream of the clock counter (drives its `time_in`/`load_new_time`) and the alarm register (`load_new_alarm`). Abandoned entries are discarded after a programmable idle timeout.

## Interface
- `TIMEOUT_SECS`, default 10: number of `one_second` ticks with no key before a partial entry is discarded; legal range 1..255.
- `clk`  in  1  system clock.
- `reset`  in  1  reset, synchronous, active-high.
- `one_second`  in  1  one-cycle tick, once per second.
- `key_valid`  in  1  one-cycle strobe: `key` holds a new keypress.
- `key`  in  4  key code: 0-9 digit, 4'hA SET_TIME, 4'hB SET_ALARM, 4'hC CLEAR, 4'hD-4'hF ignored.
- `key_buffer`  out  16  entered digits, BCD, {ms_hour, ls_hour, ms_min, ls_min}; feeds `time_in` downstream.
- `digit_count`  out  3  digits held, 0..4.
- `load_new_time`  out  1  one-cycle strobe, `key_buffer` valid.
- `load_new_alarm`  out  1  one-cycle strobe, `key_buffer` valid.
- `entry_error`  out  1  one-cycle strobe, rejected command.

## Operation
- States: IDLE (count 0), ENTRY (count 1-3), FULL (count 4), LOAD_T, LOAD_A.
- Digit key in IDLE/ENTRY: `key_buffer <= {key_buffer[11:0], key}`, count+1; reaching 4 -> FULL. Digit in FULL: ignored, no error.
- SET_TIME in FULL with valid buffer -> LOAD_T; SET_ALARM likewise -> LOAD_A.
- Valid buffer: ms_hour<=2; ls_hour<=9, and <=3 when ms_hour==2; ms_min<=5; ls_min<=9.
- SET_TIME/SET_ALARM in FULL with invalid buffer, or in IDLE/ENTRY: `entry_error` pulse, -> IDLE.
- CLEAR in any state except LOAD_*: -> IDLE, no error.
- Codes D-F: ignored everywhere; do not restart timeout.
- LOAD_T/LOAD_A: last exactly one cycle, strobe asserted, `key_buffer` unchanged; unconditionally -> IDLE. Any key during LOAD_* is dropped.
- Entering IDLE from any path: `key_buffer`=16'h0000, count=0.
- Timeout: 8-bit idle counter, cleared on every accepted key (digit, SET, CLEAR), held at 0 in IDLE. In ENTRY/FULL incremented on `one_second`; when it would reach TIMEOUT_SECS -> IDLE, no error.
- Simultaneous `key_valid` and `one_second`: key is processed, counter cleared, timeout not taken that cycle.
- `reset` overrides everything, including mid-entry and LOAD_*.

## Timing
- All outputs registered. Reset values: `key_buffer`=0, `digit_count`=0, all strobes 0, state IDLE, idle counter 0.
- Key sampled at edge N -> `key_buffer`/`digit_count` updated after edge N.
- SET key sampled at edge N -> strobe high for the cycle after edge N, deasserted after edge N+1; `key_buffer` holds the entered value across edge N+1 so downstream samples it with the strobe; cleared after edge N+1.
- `entry_error` high for the one cycle after the offending key's edge.
- Timeout taken on the edge the TIMEOUT_SECS-th tick is sampled; cleared outputs visible the next cycle.
- `load_new_time`, `load_new_alarm`, `entry_error` mutually exclusive.

## Structure
- Shared package `al_pkg`: key code constants (KEY_SET_TIME, KEY_SET_ALARM, KEY_CLEAR), state encoding, BCD digit typedef; reused by the keypad decoder and alarm register.
- Sub-module `al_bcd_time_check`: combinational 16-bit BCD HH:MM validity check, also reusable by the alarm register.

## Test plan
- Digits 1,2,3,4 then SET_TIME -> `key_buffer`=16'h1234, `digit_count`=4; `load_new_time` high one cycle with buffer 16'h1234; next cycle buffer 16'h0000, count 0.
- Digits 2,4,0,0 then SET_ALARM -> `entry_error` one cycle, no load strobe, buffer cleared; repeat with 2,3,5,9 -> `load_new_alarm` with 16'h2359.
- Digits 0,7,3,0,9 -> 5th digit ignored, buffer 16'h0730; CLEAR -> buffer 0, no error; SET_TIME with 2 digits -> `entry_error`.
- TIMEOUT_SECS=3: digit 5, then 3 `one_second` ticks -> buffer 0 after third tick; with digit 5 coincident with the 3rd tick -> no timeout, buffer 16'h0055 if second digit 5.
- `reset` asserted mid-entry (buffer 16'h0012) and during LOAD_T -> all outputs 0 next cycle, strobe truncated; key during LOAD_T dropped.

Source files
------------

// File: rtl/al_pkg.sv
// Shared alarm-clock definitions: key codes, entry FSM encoding, BCD digit type.
package al_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t KEY_SET_TIME  = 4'hA;
  localparam bcd_digit_t KEY_SET_ALARM = 4'hB;
  localparam bcd_digit_t KEY_CLEAR     = 4'hC;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ENTRY  = 3'd1,
    ST_FULL   = 3'd2,
    ST_LOAD_T = 3'd3,
    ST_LOAD_A = 3'd4
  } state_t;

  // True for the numeric keys 0-9.
  function automatic logic is_digit(bcd_digit_t k);
    return (k <= 4'd9);
  endfunction

endpackage

// File: rtl/al_key_entry_if.sv
// Keypad-entry bus: keypad strobes in, entered value and load strobes out.
interface al_key_entry_if;
  import al_pkg::*;

  logic       one_second;
  logic       key_valid;
  bcd_digit_t key;
  logic [15:0] key_buffer;
  logic [2:0] digit_count;
  logic       load_new_time;
  logic       load_new_alarm;
  logic       entry_error;

  // Source of keypad events / sink of the entered value.
  modport master (
    output one_second, key_valid, key,
    input  key_buffer, digit_count, load_new_time, load_new_alarm, entry_error
  );

  // The entry stage itself.
  modport slave (
    input  one_second, key_valid, key,
    output key_buffer, digit_count, load_new_time, load_new_alarm, entry_error
  );
endinterface

// File: rtl/al_bcd_time_check.sv
// Combinational check that a 4-digit BCD value {HH,MM} is a legal 24-hour time.
module al_bcd_time_check
  import al_pkg::*;
(
  input  logic [15:0] bcd,
  output logic        valid
);

  bcd_digit_t ms_hour;
  bcd_digit_t ls_hour;
  bcd_digit_t ms_min;
  bcd_digit_t ls_min;

  assign ms_hour = bcd[15:12];
  assign ls_hour = bcd[11:8];
  assign ms_min  = bcd[7:4];
  assign ls_min  = bcd[3:0];

  // Hours 00-23, minutes 00-59.
  always_comb begin
    valid = (ms_hour <= 4'd2) &&
            (ls_hour <= ((ms_hour == 4'd2) ? 4'd3 : 4'd9)) &&
            (ms_min  <= 4'd5) &&
            (ls_min  <= 4'd9);
  end

endmodule

// File: rtl/al_key_entry.sv
// Keypad entry stage: gathers four BCD digits, validates HH:MM and issues a
// one-cycle load strobe for the clock counter or alarm register. Partial
// entries are dropped after TIMEOUT_SECS idle seconds.
module al_key_entry
  import al_pkg::*;
#(
  parameter int TIMEOUT_SECS = 10
) (
  input  logic           clk,
  input  logic           reset,
  al_key_entry_if.slave  bus
);

  state_t      state_q, state_n;
  logic [15:0] buf_q, buf_n;
  logic [2:0]  cnt_q, cnt_n;
  logic [7:0]  idle_q, idle_n;
  logic        lt_q, lt_n;
  logic        la_q, la_n;
  logic        err_q, err_n;

  logic        buf_ok;
  logic        key_acc;
  logic        tick_expire;

  al_bcd_time_check u_check (
    .bcd   (buf_q),
    .valid (buf_ok)
  );

  // Codes D-F never count as a keypress, so they leave the idle timer running.
  assign key_acc     = bus.key_valid && (bus.key <= KEY_CLEAR);
  assign tick_expire = (idle_q + 8'd1) == 8'(TIMEOUT_SECS);

  // Next-state and next-output decode; every path into IDLE wipes the entry.
  always_comb begin
    state_n = state_q;
    buf_n   = buf_q;
    cnt_n   = cnt_q;
    idle_n  = idle_q;
    lt_n    = 1'b0;
    la_n    = 1'b0;
    err_n   = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_ENTRY: begin
        if (key_acc) begin
          idle_n = 8'd0;
          if (is_digit(bus.key)) begin
            buf_n   = {buf_q[11:0], bus.key};
            cnt_n   = cnt_q + 3'd1;
            state_n = (cnt_q == 3'd3) ? ST_FULL : ST_ENTRY;
          end else begin
            // SET with fewer than four digits is an error; CLEAR is silent.
            err_n   = (bus.key != KEY_CLEAR);
            state_n = ST_IDLE;
            buf_n   = 16'h0000;
            cnt_n   = 3'd0;
          end
        end else if (state_q == ST_ENTRY && bus.one_second) begin
          if (tick_expire) begin
            state_n = ST_IDLE;
            buf_n   = 16'h0000;
            cnt_n   = 3'd0;
            idle_n  = 8'd0;
          end else begin
            idle_n = idle_q + 8'd1;
          end
        end
      end

      ST_FULL: begin
        if (key_acc) begin
          idle_n = 8'd0;
          if (bus.key == KEY_SET_TIME && buf_ok) begin
            state_n = ST_LOAD_T;
            lt_n    = 1'b1;
          end else if (bus.key == KEY_SET_ALARM && buf_ok) begin
            state_n = ST_LOAD_A;
            la_n    = 1'b1;
          end else if (!is_digit(bus.key)) begin
            // Invalid SET or CLEAR; a fifth digit falls through and is ignored.
            err_n   = (bus.key != KEY_CLEAR);
            state_n = ST_IDLE;
            buf_n   = 16'h0000;
            cnt_n   = 3'd0;
          end
        end else if (bus.one_second) begin
          if (tick_expire) begin
            state_n = ST_IDLE;
            buf_n   = 16'h0000;
            cnt_n   = 3'd0;
            idle_n  = 8'd0;
          end else begin
            idle_n = idle_q + 8'd1;
          end
        end
      end

      ST_LOAD_T, ST_LOAD_A: begin
        // Buffer was held for the strobe cycle; any key here is dropped.
        state_n = ST_IDLE;
        buf_n   = 16'h0000;
        cnt_n   = 3'd0;
        idle_n  = 8'd0;
      end

      default: begin
        state_n = ST_IDLE;
        buf_n   = 16'h0000;
        cnt_n   = 3'd0;
        idle_n  = 8'd0;
      end
    endcase
  end

  // State and registered outputs; reset overrides any entry or load in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      buf_q   <= 16'h0000;
      cnt_q   <= 3'd0;
      idle_q  <= 8'd0;
      lt_q    <= 1'b0;
      la_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      buf_q   <= buf_n;
      cnt_q   <= cnt_n;
      idle_q  <= idle_n;
      lt_q    <= lt_n;
      la_q    <= la_n;
      err_q   <= err_n;
    end
  end

  assign bus.key_buffer     = buf_q;
  assign bus.digit_count    = cnt_q;
  assign bus.load_new_time  = lt_q;
  assign bus.load_new_alarm = la_q;
  assign bus.entry_error    = err_q;

endmodule
